// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   BCD_DIGIT_W   : bits per BCD digit
//   BCD_MAX_DIGIT : largest legal value of one BCD digit
//   state_t       : converter FSM states
//   min_bin_width : smallest binary width able to hold 10^digits - 1
package bcd2bin_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest w with 2^w > 10^digits - 1, i.e. 2^w >= 10^digits.
    function automatic int unsigned min_bin_width(input int unsigned digits);
        longint unsigned limit;
        int unsigned     w;
        limit = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            limit = limit * 64'd10;
        end
        w = 0;
        while ((64'd1 << w) < limit) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle for bcd2bin_seq.
//   in_valid/in_ready/in_bcd      : input side, packed BCD, digit 0 in [3:0]
//   out_valid/out_ready/out_bin   : result side, binary value
//   out_err                       : input contained a nibble > 9
// slave modport is the converter, master modport is the producer/consumer.
interface bcd2bin_seq_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      out_bin;
    logic                  out_err;

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble correction for one BCD digit.
//   nibble   : digit after the right shift
//   adjusted : nibble - 3 when nibble >= 8, else nibble unchanged
module bcd_nibble_adjust
    import bcd2bin_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] nibble,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // A weight-8 bit shifted in from the digit above is really worth 5,
    // so remove the excess 3. Cannot underflow since nibble >= 8.
    always_comb begin
        adjusted = (nibble >= BCD_DIGIT_W'(8)) ? nibble - BCD_DIGIT_W'(3) : nibble;
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one
// shift/adjust iteration per clock, BIN_W iterations per conversion.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : bcd2bin_seq_if slave (input and result handshakes)
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    bcd2bin_seq_if.slave        bus
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < min_bin_width(DIGITS)) begin : g_width_check
        $error("bcd2bin_seq: BIN_W too small for DIGITS");
    end

    state_t             state, state_next;
    logic [SR_W-1:0]    sr, sr_shift, sr_next;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               err_flag;
    logic               in_err;
    logic               accept;
    logic               last_iter;
    logic [BIN_W-1:0]   bin_q;
    logic               err_q;

    // One iteration: shift {bcd, bin} right, then correct every bcd digit.
    always_comb begin
        sr_shift = sr >> 1;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nibble   (sr_shift[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        sr_next = {bcd_adj, sr_shift[BIN_W-1:0]};
    end

    always_comb begin
        in_err = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) begin
                in_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        last_iter     = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (bus.in_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                last_iter = (cnt == CNT_W'(BIN_W - 1));
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr       <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                sr       <= {bus.in_bcd, {BIN_W{1'b0}}};
                cnt      <= '0;
                err_flag <= in_err;
            end else if (state == CONV) begin
                sr  <= sr_next;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    bin_q <= err_flag ? '0 : sr_next[BIN_W-1:0];
                    err_q <= err_flag;
                end
            end
        end
    end

    assign bus.out_bin = bin_q;
    assign bus.out_err = err_q;

endmodule
